// File: rtl/mcycle_ctrl_pkg.sv
// Shared constants, state encoding and instruction classifier for the
// multi-cycle accumulator control unit.
package mcycle_ctrl_pkg;

   localparam int unsigned OPC_NOOP = 0;
   localparam int unsigned OPC_LOD  = 1;
   localparam int unsigned OPC_STR  = 2;
   localparam int unsigned OPC_BRA  = 4;
   localparam int unsigned OPC_BRR  = 5;
   localparam int unsigned OPC_BNE  = 6;
   localparam int unsigned OPC_ALU  = 8;
   localparam int unsigned OPC_HLT  = 15;

   localparam int unsigned AM_IMM = 8;
   localparam int unsigned AM_REG = 0;

   localparam int unsigned ALU_REG   = 0;
   localparam int unsigned ALU_IMM   = 1;
   localparam int unsigned ALU_ADDR  = 2;
   localparam int unsigned ALU_PCINC = 3;

   typedef enum logic [3:0] {
      ST_START0   = 4'd0,
      ST_START1   = 4'd1,
      ST_FETCH    = 4'd2,
      ST_DECODE   = 4'd3,
      ST_ALU_EX   = 4'd4,
      ST_ALU_WB   = 4'd5,
      ST_BRANCH   = 4'd6,
      ST_MEM_ADDR = 4'd7,
      ST_MEM_WAIT = 4'd8,
      ST_MEM_WB   = 4'd9,
      ST_HALT     = 4'd10,
      ST_ERROR    = 4'd11
   } state_e;

   typedef enum logic [2:0] {
      IC_NOOP,
      IC_ALU,
      IC_BRANCH,
      IC_MEM,
      IC_HALT,
      IC_ILLEGAL
   } iclass_e;

   // Opcode and mode arrive zero-extended; an ALU op with an unknown mode is illegal.
   function automatic iclass_e classify(input int unsigned op, input int unsigned mm);
      case (op)
         OPC_NOOP:                  return IC_NOOP;
         OPC_ALU:                   return (mm == AM_IMM || mm == AM_REG) ? IC_ALU : IC_ILLEGAL;
         OPC_BRA, OPC_BRR, OPC_BNE: return IC_BRANCH;
         OPC_LOD, OPC_STR:          return IC_MEM;
         OPC_HLT:                   return IC_HALT;
         default:                   return IC_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/mcycle_ctrl_if.sv
// Instruction/status inputs and datapath/memory control outputs of the
// control unit; master is the controller, slave is the datapath side.
interface mcycle_ctrl_if #(
   parameter int unsigned OP_W     = 4,
   parameter int unsigned MM_W     = 4,
   parameter int unsigned ALU_OP_W = 2
);
   logic [OP_W-1:0]     OPCODE;
   logic [MM_W-1:0]     MM;
   logic [MM_W-1:0]     STAT;
   logic                MEM_ACK;
   logic                RF_WE;
   logic [ALU_OP_W-1:0] ALU_OP;
   logic                WB_SEL;
   logic                RD_SEL;
   logic                PC_SEL;
   logic                PC_WRITE;
   logic                PC_RST;
   logic                BR_SEL;
   logic                MEM_REQ;
   logic                MEM_WE;
   logic                HALTED;
   logic                ERR;
   logic [3:0]          STATE;

   modport master (
      input  OPCODE, MM, STAT, MEM_ACK,
      output RF_WE, ALU_OP, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST,
             BR_SEL, MEM_REQ, MEM_WE, HALTED, ERR, STATE
   );

   modport slave (
      output OPCODE, MM, STAT, MEM_ACK,
      input  RF_WE, ALU_OP, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST,
             BR_SEL, MEM_REQ, MEM_WE, HALTED, ERR, STATE
   );
endinterface

// File: rtl/mcycle_ctrl_wait.sv
// Memory-wait cycle counter with saturating count and timeout detect.
module mcycle_ctrl_wait #(
   parameter int unsigned MEM_TO = 15,
   parameter int unsigned CNT_W  = $clog2(MEM_TO + 1)
) (
   input  logic CLK,
   input  logic RST_F,
   input  logic clr,
   input  logic en,
   output logic timeout
);
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

   always_comb begin
      cnt_inc = (cnt_q == CNT_W'(MEM_TO)) ? cnt_q : cnt_q + CNT_W'(1);
      cnt_d   = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_inc;
   end

   // Timeout fires in the wait cycle whose count reaches MEM_TO, so at most MEM_TO wait cycles elapse.
   assign timeout = en && (cnt_inc == CNT_W'(MEM_TO));

   always_ff @(posedge CLK or negedge RST_F) begin
      if (!RST_F)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/ALU/branch/load-store and
// decodes datapath, PC and memory-handshake controls from the present state.
module mcycle_ctrl #(
   parameter int unsigned OP_W         = 4,
   parameter int unsigned MM_W         = 4,
   parameter int unsigned ALU_OP_W     = 2,
   parameter int unsigned MEM_TO       = 15,
   parameter bit          ILLEGAL_TRAP = 1'b1
) (
   input logic          CLK,
   input logic          RST_F,
   mcycle_ctrl_if.master bus
);
   import mcycle_ctrl_pkg::*;

   localparam int unsigned CNT_W = $clog2(MEM_TO + 1);

   state_e          state_q, state_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [MM_W-1:0] mm_q, mm_d;
   iclass_e         dec_class;
   logic            timeout;
   logic            stat_hit, taken, rd_reg;

   logic                rf_we, wb_sel, rd_sel, pc_sel, pc_write, pc_rst, br_sel;
   logic                mem_req, mem_we, halted, err;
   logic [ALU_OP_W-1:0] alu_op;

   assign dec_class = classify(32'(bus.OPCODE), 32'(bus.MM));

   mcycle_ctrl_wait #(
      .MEM_TO (MEM_TO),
      .CNT_W  (CNT_W)
   ) u_wait (
      .CLK     (CLK),
      .RST_F   (RST_F),
      .clr     (state_q == ST_MEM_ADDR),
      .en      (state_q == ST_MEM_WAIT),
      .timeout (timeout)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mm_d    = mm_q;
      case (state_q)
         ST_START0: state_d = ST_START1;
         ST_START1: state_d = ST_FETCH;
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            op_d = bus.OPCODE;
            mm_d = bus.MM;
            case (dec_class)
               IC_NOOP:   state_d = ST_FETCH;
               IC_ALU:    state_d = ST_ALU_EX;
               IC_BRANCH: state_d = ST_BRANCH;
               IC_MEM:    state_d = ST_MEM_ADDR;
               IC_HALT:   state_d = ST_HALT;
               default:   state_d = ILLEGAL_TRAP ? ST_ERROR : ST_FETCH;
            endcase
         end
         ST_ALU_EX:   state_d = ST_ALU_WB;
         ST_ALU_WB:   state_d = ST_FETCH;
         ST_BRANCH:   state_d = ST_FETCH;
         ST_MEM_ADDR: state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: begin
            // Acknowledge takes priority over a coincident timeout.
            if (bus.MEM_ACK)
               state_d = (op_q == OP_W'(OPC_LOD)) ? ST_MEM_WB : ST_FETCH;
            else if (timeout)
               state_d = ST_ERROR;
         end
         ST_MEM_WB:   state_d = ST_FETCH;
         ST_HALT:     state_d = ST_HALT;
         ST_ERROR:    state_d = ST_ERROR;
         default:     state_d = ST_ERROR;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_F) begin
      if (!RST_F) begin
         state_q <= ST_START0;
         op_q    <= '0;
         mm_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mm_q    <= mm_d;
      end
   end

   always_comb begin
      stat_hit = |(mm_q & bus.STAT);
      taken    = (op_q == OP_W'(OPC_BNE)) ? !stat_hit : stat_hit;
      rd_reg   = (mm_q == MM_W'(AM_REG));
      rf_we    = 1'b0;
      alu_op   = '0;
      wb_sel   = 1'b0;
      rd_sel   = 1'b0;
      pc_sel   = 1'b0;
      pc_write = 1'b0;
      pc_rst   = 1'b0;
      br_sel   = 1'b0;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      halted   = 1'b0;
      err      = 1'b0;
      case (state_q)
         ST_START0: pc_rst = 1'b1;
         ST_FETCH: begin
            pc_write = 1'b1;
            alu_op   = ALU_OP_W'(ALU_PCINC);
         end
         ST_ALU_EX: begin
            alu_op = rd_reg ? ALU_OP_W'(ALU_REG) : ALU_OP_W'(ALU_IMM);
            rd_sel = rd_reg;
         end
         ST_ALU_WB: begin
            rf_we  = 1'b1;
            rd_sel = rd_reg;
         end
         ST_BRANCH: begin
            if (taken) begin
               pc_sel   = 1'b1;
               pc_write = 1'b1;
               br_sel   = (op_q != OP_W'(OPC_BRR));
            end
         end
         ST_MEM_ADDR: alu_op = ALU_OP_W'(ALU_ADDR);
         ST_MEM_WAIT: begin
            mem_req = 1'b1;
            mem_we  = (op_q == OP_W'(OPC_STR));
         end
         ST_MEM_WB: begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
         end
         ST_HALT:  halted = 1'b1;
         ST_ERROR: err    = 1'b1;
         default: ;
      endcase
   end

   assign bus.RF_WE    = rf_we;
   assign bus.ALU_OP   = alu_op;
   assign bus.WB_SEL   = wb_sel;
   assign bus.RD_SEL   = rd_sel;
   assign bus.PC_SEL   = pc_sel;
   assign bus.PC_WRITE = pc_write;
   assign bus.PC_RST   = pc_rst;
   assign bus.BR_SEL   = br_sel;
   assign bus.MEM_REQ  = mem_req;
   assign bus.MEM_WE   = mem_we;
   assign bus.HALTED   = halted;
   assign bus.ERR      = err;
   assign bus.STATE    = state_q;
endmodule

// File: tb/tb_mcycle_ctrl.sv
// Randomized bench for mcycle_ctrl: each instruction is expanded into its
// expected per-cycle control trace and compared cycle by cycle.
module tb_mcycle_ctrl;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned MM_W   = 4;
   localparam int unsigned AW     = 2;
   localparam int unsigned MEM_TO = 6;

   typedef struct packed {
      logic          rf_we;
      logic [AW-1:0] alu_op;
      logic          wb_sel;
      logic          rd_sel;
      logic          pc_sel;
      logic          pc_write;
      logic          pc_rst;
      logic          br_sel;
      logic          mem_req;
      logic          mem_we;
      logic          halted;
      logic          err;
   } outs_t;

   logic CLK = 1'b0;
   logic RST_F = 1'b0;
   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   always #5 CLK = ~CLK;

   mcycle_ctrl_if #(.OP_W(OP_W), .MM_W(MM_W), .ALU_OP_W(AW)) bus ();

   mcycle_ctrl #(
      .OP_W         (OP_W),
      .MM_W         (MM_W),
      .ALU_OP_W     (AW),
      .MEM_TO       (MEM_TO),
      .ILLEGAL_TRAP (1'b1)
   ) dut (
      .CLK   (CLK),
      .RST_F (RST_F),
      .bus   (bus)
   );

   function automatic logic [3:0] rnd4();
      return 4'($urandom);
   endfunction

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   function automatic outs_t obs();
      outs_t o;
      o.rf_we    = bus.RF_WE;
      o.alu_op   = bus.ALU_OP;
      o.wb_sel   = bus.WB_SEL;
      o.rd_sel   = bus.RD_SEL;
      o.pc_sel   = bus.PC_SEL;
      o.pc_write = bus.PC_WRITE;
      o.pc_rst   = bus.PC_RST;
      o.br_sel   = bus.BR_SEL;
      o.mem_req  = bus.MEM_REQ;
      o.mem_we   = bus.MEM_WE;
      o.halted   = bus.HALTED;
      o.err      = bus.ERR;
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input string tag, input logic [3:0] opc, input logic [3:0] mm,
                       input logic [3:0] stat, input logic ack, input outs_t e);
      @(posedge CLK);
      #1;
      bus.OPCODE  = opc;
      bus.MM      = mm;
      bus.STAT    = stat;
      bus.MEM_ACK = ack;
      #1 chk(tag, 32'(obs()), 32'(e));
   endtask

   task automatic do_reset();
      outs_t e;
      @(posedge CLK);
      #1;
      RST_F = 1'b0;
      bus.OPCODE = rnd4(); bus.MM = rnd4(); bus.STAT = rnd4(); bus.MEM_ACK = rbit();
      e = '0;
      e.pc_rst = 1'b1;
      #1 chk("rst_async", 32'(obs()), 32'(e));
      repeat (2) begin
         @(posedge CLK);
         #2 chk("rst_hold", 32'(obs()), 32'(e));
      end
      @(posedge CLK);
      #1 RST_F = 1'b1;
      #1 chk("start0", 32'(obs()), 32'(e));
      e = '0;
      step("start1", rnd4(), rnd4(), rnd4(), rbit(), e);
   endtask

   // kind: 0 = back to fetch, 1 = halted, 2 = error
   task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                            input int unsigned d, output int unsigned kind);
      outs_t e;
      bit    taken, done, ack;
      kind = 0;
      e = '0;
      e.pc_write = 1'b1;
      e.alu_op   = AW'(3);
      step("fetch", rnd4(), rnd4(), rnd4(), rbit(), e);
      e = '0;
      step("decode", op, mm, rnd4(), rbit(), e);
      case (op)
         4'd0: ;
         4'd8: begin
            if (mm == 4'd8 || mm == 4'd0) begin
               e = '0;
               e.alu_op = (mm == 4'd8) ? AW'(1) : AW'(0);
               e.rd_sel = (mm == 4'd0);
               step("alu_ex", rnd4(), rnd4(), rnd4(), rbit(), e);
               e.alu_op = '0;
               e.rf_we  = 1'b1;
               step("alu_wb", rnd4(), rnd4(), rnd4(), rbit(), e);
            end else begin
               kind = 2;
            end
         end
         4'd4, 4'd5, 4'd6: begin
            taken = (op == 4'd6) ? ((mm & stat) == 4'd0) : ((mm & stat) != 4'd0);
            e = '0;
            if (taken) begin
               e.pc_sel   = 1'b1;
               e.pc_write = 1'b1;
               e.br_sel   = (op != 4'd5);
            end
            step("branch", rnd4(), rnd4(), stat, rbit(), e);
         end
         4'd1, 4'd2: begin
            e = '0;
            e.alu_op = AW'(2);
            step("mem_addr", rnd4(), rnd4(), rnd4(), rbit(), e);
            done = 1'b0;
            for (int unsigned k = 1; k <= MEM_TO && !done; k++) begin
               e = '0;
               e.mem_req = 1'b1;
               e.mem_we  = (op == 4'd2);
               ack = (k == d);
               step("mem_wait", rnd4(), rnd4(), rnd4(), ack, e);
               done = ack;
            end
            if (!done) begin
               kind = 2;
            end else if (op == 4'd1) begin
               e = '0;
               e.rf_we  = 1'b1;
               e.wb_sel = 1'b1;
               step("mem_wb", rnd4(), rnd4(), rnd4(), rbit(), e);
            end
         end
         4'd15: kind = 1;
         default: kind = 2;
      endcase
   endtask

   task automatic hold(input int unsigned kind, input int unsigned n);
      outs_t e;
      e = '0;
      if (kind == 1) e.halted = 1'b1;
      else           e.err    = 1'b1;
      for (int unsigned i = 0; i < n; i++)
         step((kind == 1) ? "halt_sticky" : "err_sticky", rnd4(), rnd4(), rnd4(), rbit(), e);
   endtask

   task automatic run_and_recover(input logic [3:0] op, input logic [3:0] mm,
                                  input logic [3:0] stat, input int unsigned d);
      int unsigned kind;
      run_instr(op, mm, stat, d, kind);
      if (kind != 0) begin
         hold(kind, 10);
         do_reset();
      end
   endtask

   initial begin
      outs_t       e;
      logic [3:0]  ops [12];
      logic [3:0]  op, mm;
      ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd8, 4'd8, 4'd15, 4'd3, 4'd7};
      bus.OPCODE = '0; bus.MM = '0; bus.STAT = '0; bus.MEM_ACK = 1'b0;
      #2;
      e = '0;
      e.pc_rst = 1'b1;
      chk("reset_state", 32'(obs()), 32'(e));
      do_reset();

      run_and_recover(4'd8, 4'd8, 4'd0, 1);
      run_and_recover(4'd8, 4'd8, 4'd0, 1);
      run_and_recover(4'd5, 4'd4, 4'd4, 1);
      run_and_recover(4'd6, 4'd4, 4'd4, 1);
      run_and_recover(4'd4, 4'd4, 4'd0, 1);
      run_and_recover(4'd1, 4'd0, 4'd0, 3);
      run_and_recover(4'd1, 4'd8, 4'd0, MEM_TO);
      run_and_recover(4'd2, 4'd0, 4'd0, MEM_TO + 1);
      run_and_recover(4'd15, 4'd0, 4'd0, 1);
      run_and_recover(4'd3, 4'd0, 4'd0, 1);

      // reset while a store is waiting on memory
      begin
         int unsigned kind;
         run_instr(4'd0, 4'd0, 4'd0, 1, kind);
         e = '0; e.pc_write = 1'b1; e.alu_op = AW'(3);
         step("fetch", rnd4(), rnd4(), rnd4(), 1'b0, e);
         e = '0;
         step("decode", 4'd2, 4'd0, 4'd0, 1'b0, e);
         e.alu_op = AW'(2);
         step("mem_addr", rnd4(), rnd4(), rnd4(), 1'b0, e);
         e = '0; e.mem_req = 1'b1; e.mem_we = 1'b1;
         step("mem_wait", rnd4(), rnd4(), rnd4(), 1'b0, e);
         step("mem_wait", rnd4(), rnd4(), rnd4(), 1'b0, e);
         do_reset();
      end

      for (int n = 0; n < 80; n++) begin
         op = ops[$urandom_range(0, 11)];
         mm = rnd4();
         if (op == 4'd8 && $urandom_range(0, 3) != 0)
            mm = rbit() ? 4'd8 : 4'd0;
         run_and_recover(op, mm, rnd4(), $urandom_range(1, MEM_TO + 1));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end
endmodule
